// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared FSM states, RV32I opcode/funct fields and ALU codes.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        WAIT      = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    localparam logic [6:0]  OP_RTYPE   = 7'b0110011;
    localparam logic [6:0]  OP_ITYPE   = 7'b0010011;
    localparam logic [6:0]  OP_SYSTEM  = 7'b1110011;

    localparam logic [6:0]  F7_BASE    = 7'b0000000;
    localparam logic [6:0]  F7_ALT     = 7'b0100000;

    localparam logic [2:0]  F3_ADD     = 3'b000;
    localparam logic [2:0]  F3_SLT     = 3'b010;
    localparam logic [2:0]  F3_OR      = 3'b110;
    localparam logic [2:0]  F3_AND     = 3'b111;

    localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

    localparam logic [2:0]  ALU_ADD    = 3'b010;
    localparam logic [2:0]  ALU_SUB    = 3'b110;
    localparam logic [2:0]  ALU_AND    = 3'b000;
    localparam logic [2:0]  ALU_OR     = 3'b001;
    localparam logic [2:0]  ALU_SLT    = 3'b111;

endpackage
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode
// Description : Combinational RV32I subset decoder (ALU op, B-select, imm).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] i_ir,
    output logic [2:0]  o_alu_control,
    output logic        o_alu_src,
    output logic [31:0] o_imm,
    output logic        o_is_illegal,
    output logic        o_is_ecall
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode   = i_ir[6:0];
    assign w_funct3   = i_ir[14:12];
    assign w_funct7   = i_ir[31:25];
    assign o_imm      = {{20{i_ir[31]}}, i_ir[31:20]};
    assign o_is_ecall = (i_ir == ECALL_WORD);

    always_comb begin
        o_alu_control = ALU_AND;
        o_alu_src     = 1'b0;
        o_is_illegal  = 1'b1;
        case (w_opcode)
            OP_RTYPE: begin
                if (w_funct7 == F7_BASE) begin
                    case (w_funct3)
                        F3_ADD: begin o_alu_control = ALU_ADD; o_is_illegal = 1'b0; end
                        F3_SLT: begin o_alu_control = ALU_SLT; o_is_illegal = 1'b0; end
                        F3_OR:  begin o_alu_control = ALU_OR;  o_is_illegal = 1'b0; end
                        F3_AND: begin o_alu_control = ALU_AND; o_is_illegal = 1'b0; end
                        default: ;
                    endcase
                end else if (w_funct7 == F7_ALT && w_funct3 == F3_ADD) begin
                    o_alu_control = ALU_SUB;
                    o_is_illegal  = 1'b0;
                end
            end
            OP_ITYPE: begin
                o_alu_src = 1'b1;
                case (w_funct3)
                    F3_ADD: begin o_alu_control = ALU_ADD; o_is_illegal = 1'b0; end
                    F3_SLT: begin o_alu_control = ALU_SLT; o_is_illegal = 1'b0; end
                    F3_OR:  begin o_alu_control = ALU_OR;  o_is_illegal = 1'b0; end
                    F3_AND: begin o_alu_control = ALU_AND; o_is_illegal = 1'b0; end
                    default: o_alu_src = 1'b0;
                endcase
            end
            OP_SYSTEM: begin
                if (o_is_ecall) o_is_illegal = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Multicycle RV32I fetch/decode controller driving the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               instr_req,
    output logic [31:0]        instr_addr,
    input  logic               instr_ready,
    input  logic               instr_valid,
    input  logic [31:0]        instr_rdata,
    output logic [4:0]         rs_1,
    output logic [4:0]         rs_2,
    output logic [4:0]         rd_0,
    output logic [2:0]         alu_control,
    output logic               alu_src,
    output logic [31:0]        imm,
    output logic               write_rb,
    output logic               halted,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    state_t             state_q,       state_d;
    logic [31:0]        pc_q,          pc_d;
    logic [31:0]        ir_q,          ir_d;
    logic [COUNT_W-1:0] count_q,       count_d;
    logic               instr_req_q,   instr_req_d;
    logic               write_rb_q,    write_rb_d;
    logic               halted_q,      halted_d;
    logic               illegal_q,     illegal_d;
    logic [2:0]         alu_control_q, alu_control_d;
    logic               alu_src_q,     alu_src_d;
    logic [31:0]        imm_q,         imm_d;

    logic [2:0]         w_alu_control;
    logic               w_alu_src;
    logic [31:0]        w_imm;
    logic               w_is_illegal;
    logic               w_is_ecall;
    logic               w_fetch_fire;
    logic               w_in_exec;

    // Decoding the next IR lets the decode outputs register on DECODE entry.
    instr_decode u_instr_decode (
        .i_ir          (ir_d),
        .o_alu_control (w_alu_control),
        .o_alu_src     (w_alu_src),
        .o_imm         (w_imm),
        .o_is_illegal  (w_is_illegal),
        .o_is_ecall    (w_is_ecall)
    );

    assign w_fetch_fire = (state_q == FETCH) && instr_req_q && instr_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        case (state_q)
            FETCH: begin
                if (w_fetch_fire) begin
                    if (instr_valid) begin
                        ir_d    = instr_rdata;
                        state_d = DECODE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (instr_valid) begin
                    ir_d    = instr_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (w_is_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = HALT;
                end else if (w_is_ecall) begin
                    state_d   = HALT;
                end else begin
                    state_d   = EXECUTE;
                end
            end
            EXECUTE:   state_d = WRITEBACK;
            WRITEBACK: begin
                pc_d    = pc_q + 32'd4;
                count_d = count_q + COUNT_W'(1);
                state_d = FETCH;
            end
            HALT:      state_d = HALT;
            default:   state_d = HALT;
        endcase

        w_in_exec     = (state_d == DECODE) || (state_d == EXECUTE) || (state_d == WRITEBACK);
        instr_req_d   = (state_d == FETCH);
        write_rb_d    = (state_d == WRITEBACK);
        halted_d      = halted_q || (state_d == HALT);
        alu_control_d = w_in_exec ? w_alu_control : ALU_AND;
        alu_src_d     = w_in_exec ? w_alu_src     : 1'b0;
        imm_d         = w_imm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= PC_RESET;
            ir_q          <= 32'd0;
            count_q       <= '0;
            instr_req_q   <= 1'b0;
            write_rb_q    <= 1'b0;
            halted_q      <= 1'b0;
            illegal_q     <= 1'b0;
            alu_control_q <= ALU_AND;
            alu_src_q     <= 1'b0;
            imm_q         <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            count_q       <= count_d;
            instr_req_q   <= instr_req_d;
            write_rb_q    <= write_rb_d;
            halted_q      <= halted_d;
            illegal_q     <= illegal_d;
            alu_control_q <= alu_control_d;
            alu_src_q     <= alu_src_d;
            imm_q         <= imm_d;
        end
    end

    assign instr_req   = instr_req_q;
    assign instr_addr  = pc_q;
    assign rs_1        = ir_q[19:15];
    assign rs_2        = ir_q[24:20];
    assign rd_0        = ir_q[11:7];
    assign alu_control = alu_control_q;
    assign alu_src     = alu_src_q;
    assign imm         = imm_q;
    assign write_rb    = write_rb_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule
`default_nettype wire
